// File: rtl/tiny16_pkg.sv
// Shared definitions for the tiny16 core: opcodes, ALU encodings, FSM states,
// instruction field positions and the decoded-instruction struct.
package tiny16_pkg;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int DST_MSB = 11;
    localparam int DST_LSB = 9;
    localparam int SRC_MSB = 8;
    localparam int SRC_LSB = 6;
    localparam int IMM_MSB = 5;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_MOV = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_JZ  = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    // PASS forwards the src operand; used for moves, addresses and the JZ test
    typedef enum logic [3:0] {
        ALU_PASS = 4'h0,
        ALU_ADD  = 4'h1,
        ALU_SUB  = 4'h2,
        ALU_AND  = 4'h3,
        ALU_OR   = 4'h4,
        ALU_XOR  = 4'h5
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_HALT
    } state_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    writes_reg;
        logic    uses_imm;
        logic    is_mem_rd;
        logic    is_mem_wr;
        logic    is_jump;
        logic    is_cond;
        logic    is_halt;
        logic    is_illegal;
    } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decode of the latched instruction register.
module instr_decoder
    import tiny16_pkg::*;
(
    input  logic [15:0] ir,
    output dec_t        dec
);

    always_comb begin
        dec        = '0;
        dec.alu_op = ALU_PASS;
        case (ir[OP_MSB:OP_LSB])
            OP_NOP: ;
            OP_MOV: dec.writes_reg = 1'b1;
            OP_ADD: begin dec.writes_reg = 1'b1; dec.alu_op = ALU_ADD; end
            OP_SUB: begin dec.writes_reg = 1'b1; dec.alu_op = ALU_SUB; end
            OP_AND: begin dec.writes_reg = 1'b1; dec.alu_op = ALU_AND; end
            OP_OR:  begin dec.writes_reg = 1'b1; dec.alu_op = ALU_OR;  end
            OP_XOR: begin dec.writes_reg = 1'b1; dec.alu_op = ALU_XOR; end
            OP_LDI: begin dec.writes_reg = 1'b1; dec.uses_imm = 1'b1; end
            OP_LD:  begin dec.writes_reg = 1'b1; dec.is_mem_rd = 1'b1; end
            OP_ST:  dec.is_mem_wr = 1'b1;
            OP_JMP: begin
                dec.writes_reg = 1'b1;
                dec.uses_imm   = 1'b1;
                dec.is_jump    = 1'b1;
            end
            // JZ writes only when taken; the FSM gates writes_reg with alu_zero
            OP_JZ: begin
                dec.writes_reg = 1'b1;
                dec.uses_imm   = 1'b1;
                dec.is_jump    = 1'b1;
                dec.is_cond    = 1'b1;
            end
            OP_HLT:  dec.is_halt = 1'b1;
            default: dec.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// tiny16 fetch/decode/execute sequencer driving the register file, ALU and memory.
// Optional single-step input enabled by defining CONTROL_STEP_EN.
module control_unit
    import tiny16_pkg::*;
#(
    parameter logic [2:0] REG_PC      = 3'd7,
    parameter int         MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
`ifdef CONTROL_STEP_EN
    input  logic        step,
`endif
    input  logic [15:0] instr,
    input  logic        mem_ready,
    input  logic        alu_zero,
    output logic [2:0]  src_sel,
    output logic [2:0]  dst_sel,
    output logic        reg_in_en,
    output logic        reg_out_en,
    output logic        pc_inc,
    output logic [3:0]  alu_op,
    output logic [15:0] imm,
    output logic        imm_sel,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        halted,
    output logic        illegal,
    output logic        bus_err
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_e        state_q, state_d;
    logic [15:0]   ir_q;
    logic [CW-1:0] tmo_q;
    dec_t          dec;
    logic          fetch_req, mem_wait, tmo_hit;
    logic          ld_ir, set_ill, set_bus;
    logic [2:0]    f_dst, f_src;

    instr_decoder u_dec (
        .ir  (ir_q),
        .dec (dec)
    );

    assign f_dst = ir_q[DST_MSB:DST_LSB];
    assign f_src = ir_q[SRC_MSB:SRC_LSB];
    assign imm   = {10'd0, ir_q[IMM_MSB:0]};

`ifdef CONTROL_STEP_EN
    // Registered go flag keeps outputs a function of state only; one step
    // pulse arms exactly one fetch and the flag drops once FETCH is left.
    logic fetch_go_q;
    assign fetch_req = fetch_go_q;
    always_ff @(posedge clk) begin
        if (rst)
            fetch_go_q <= 1'b0;
        else if (state_q != ST_FETCH)
            fetch_go_q <= 1'b0;
        else if (step)
            fetch_go_q <= 1'b1;
    end
`else
    assign fetch_req = 1'b1;
`endif

    assign mem_wait = (state_q == ST_FETCH && fetch_req) ||
                      (state_q == ST_EXECUTE && (dec.is_mem_rd || dec.is_mem_wr));
    assign tmo_hit  = (MEM_TIMEOUT != 0) && mem_wait && !mem_ready &&
                      (int'(tmo_q) == MEM_TIMEOUT - 1);

    always_comb begin
        state_d    = state_q;
        ld_ir      = 1'b0;
        set_ill    = 1'b0;
        set_bus    = 1'b0;
        src_sel    = '0;
        dst_sel    = '0;
        reg_in_en  = 1'b0;
        reg_out_en = 1'b0;
        pc_inc     = 1'b0;
        alu_op     = ALU_PASS;
        imm_sel    = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                src_sel    = REG_PC;
                reg_out_en = 1'b1;
                if (fetch_req) begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        ld_ir   = 1'b1;
                        pc_inc  = 1'b1;
                        state_d = ST_DECODE;
                    end else if (tmo_hit) begin
                        set_bus = 1'b1;
                        state_d = ST_HALT;
                    end
                end
            end
            ST_DECODE: begin
                if (dec.is_illegal) begin
                    set_ill = 1'b1;
                    state_d = ST_HALT;
                end else if (dec.is_halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                src_sel    = f_src;
                dst_sel    = f_dst;
                reg_out_en = 1'b1;
                alu_op     = dec.alu_op;
                if (dec.is_mem_rd || dec.is_mem_wr) begin
                    mem_rd = dec.is_mem_rd;
                    mem_wr = dec.is_mem_wr;
                    if (mem_ready)
                        state_d = dec.is_mem_rd ? ST_WRITEBACK : ST_FETCH;
                    else if (tmo_hit) begin
                        set_bus = 1'b1;
                        state_d = ST_HALT;
                    end
                end else if (dec.is_cond) begin
                    state_d = alu_zero ? ST_WRITEBACK : ST_FETCH;
                end else begin
                    state_d = dec.writes_reg ? ST_WRITEBACK : ST_FETCH;
                end
            end
            ST_WRITEBACK: begin
                reg_in_en = 1'b1;
                dst_sel   = dec.is_jump ? REG_PC : f_dst;
                imm_sel   = dec.uses_imm;
                state_d   = ST_FETCH;
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
        // Strobes are forced quiet during reset so no partial writeback leaks out
        if (rst) begin
            src_sel    = '0;
            dst_sel    = '0;
            reg_in_en  = 1'b0;
            reg_out_en = 1'b0;
            pc_inc     = 1'b0;
            alu_op     = ALU_PASS;
            imm_sel    = 1'b0;
            mem_rd     = 1'b0;
            mem_wr     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
            tmo_q   <= '0;
            halted  <= 1'b0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ld_ir)
                ir_q <= instr;
            // Any state change clears the count, so each wait starts from zero
            if (state_d != state_q || !mem_wait)
                tmo_q <= '0;
            else if (!mem_ready && MEM_TIMEOUT != 0)
                tmo_q <= tmo_q + 1'b1;
            if (state_d == ST_HALT)
                halted <= 1'b1;
            if (set_ill)
                illegal <= 1'b1;
            if (set_bus)
                bus_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: one instruction per run followed by HLT,
// plus memory-timeout and mid-instruction reset scenarios.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = 16'h0000;
    logic        mem_ready = 1'b1;
    logic        alu_zero = 1'b0;
    logic [2:0]  src_sel, dst_sel;
    logic        reg_in_en, reg_out_en, pc_inc;
    logic [3:0]  alu_op;
    logic [15:0] imm;
    logic        imm_sel, mem_rd, mem_wr, halted, illegal, bus_err;
`ifdef CONTROL_STEP_EN
    logic        step = 1'b1;
`endif

    control_unit dut (
        .clk        (clk),
        .rst        (rst),
`ifdef CONTROL_STEP_EN
        .step       (step),
`endif
        .instr      (instr),
        .mem_ready  (mem_ready),
        .alu_zero   (alu_zero),
        .src_sel    (src_sel),
        .dst_sel    (dst_sel),
        .reg_in_en  (reg_in_en),
        .reg_out_en (reg_out_en),
        .pc_inc     (pc_inc),
        .alu_op     (alu_op),
        .imm        (imm),
        .imm_sel    (imm_sel),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .halted     (halted),
        .illegal    (illegal),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    lat;
        int    halt_at;
        int    ill;
        int    nwb;
        int    dst;
        int    imm;
        int    isel;
        int    nmw;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Leaves the bench one time unit after a falling edge with rst just released
    task automatic do_reset(input logic rdy);
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = rdy;
        repeat (2) @(negedge clk);
        #1;
        check("rst_strobes", {src_sel, dst_sel, reg_in_en, reg_out_en, pc_inc,
                              alu_op, imm_sel, mem_rd, mem_wr}, 0);
        check("rst_flags", {halted, illegal, bus_err}, 0);
        rst = 1'b0;
    endtask

    task automatic run(input string tag, input logic [15:0] word, input logic z,
                       input int lat, input int ill, input int nwb, input int dst,
                       input int immv, input int isel, input int nmw);
        exp_t e, o;
        int   npc = 0, olat = -1, ohalt = -1, onwb = 0, owb_at = -1;
        int   odst = 0, oimm = 0, oisel = 0, onmw = 0, ordh = 0;
        e.tag = tag; e.lat = lat; e.ill = ill; e.nwb = nwb;
        e.dst = dst; e.imm = immv; e.isel = isel; e.nmw = nmw;
        e.halt_at = (lat < 0) ? 2 : lat + 2;
        sb.push_back(e);
        instr    = word;
        alu_zero = z;
        do_reset(1'b1);
        for (int k = 0; k < 14; k++) begin
            #1;
            if (pc_inc) begin
                if (npc == 1) olat = k;
                npc++;
            end
            if (halted && ohalt < 0) ohalt = k;
            if (halted && mem_rd) ordh++;
            if (mem_wr) onmw++;
            if (reg_in_en) begin
                if (onwb == 0) begin
                    owb_at = k; odst = int'(dst_sel); oimm = int'(imm); oisel = int'(imm_sel);
                end
                onwb++;
            end
            if (npc > 0 && !pc_inc) instr = 16'hF000;
            @(negedge clk);
        end
        o = sb.pop_front();
        check({o.tag, "_lat"}, olat, o.lat);
        check({o.tag, "_halt_at"}, ohalt, o.halt_at);
        check({o.tag, "_illegal"}, {31'd0, illegal}, o.ill);
        check({o.tag, "_bus_err"}, {31'd0, bus_err}, 0);
        check({o.tag, "_rd_after_halt"}, ordh, 0);
        check({o.tag, "_nwb"}, onwb, o.nwb);
        check({o.tag, "_nmw"}, onmw, o.nmw);
        if (o.nwb > 0) begin
            check({o.tag, "_wb_at"}, owb_at, 3);
            check({o.tag, "_wb_dst"}, odst, o.dst);
            check({o.tag, "_wb_imm"}, oimm, o.imm);
            check({o.tag, "_wb_isel"}, oisel, o.isel);
        end
    endtask

    initial begin
        int nrd, hat, rdh;
        //        tag       word      z     lat ill nwb dst imm isel nmw
        run("add",    16'h2650, 1'b1,  4, 0, 1, 3, 16, 0, 0);
        run("ldi",    16'h740A, 1'b0,  4, 0, 1, 2, 10, 1, 0);
        run("nop",    16'h0000, 1'b0,  3, 0, 0, 0,  0, 0, 0);
        run("jz_t",   16'hBE05, 1'b1,  4, 0, 1, 7,  5, 1, 0);
        run("jz_nt",  16'hBE05, 1'b0,  3, 0, 0, 0,  0, 0, 0);
        run("jmp",    16'hA005, 1'b0,  4, 0, 1, 7,  5, 1, 0);
        run("mov",    16'h1440, 1'b0,  4, 0, 1, 2,  0, 0, 0);
        run("ld",     16'h8A40, 1'b0,  4, 0, 1, 5,  0, 0, 0);
        run("st",     16'h9A40, 1'b0,  3, 0, 0, 0,  0, 0, 1);
        run("ill_c",  16'hC000, 1'b0, -1, 1, 0, 0,  0, 0, 0);
        run("ill_e",  16'hE123, 1'b0, -1, 1, 0, 0,  0, 0, 0);
        run("hlt",    16'hF000, 1'b0, -1, 0, 0, 0,  0, 0, 0);

        // Fetch with memory never ready: bounded loop doubles as the wait limit
        instr = 16'h2650;
        do_reset(1'b0);
        nrd = 0; hat = -1; rdh = 0;
        for (int k = 0; k < 30; k++) begin
            #1;
            if (mem_rd && !halted) nrd++;
            if (halted && hat < 0) hat = k;
            if (halted && mem_rd) rdh++;
            @(negedge clk);
        end
        check("tmo_rd_cycles", nrd, 15);
        check("tmo_halt_at", hat, 15);
        check("tmo_bus_err", {31'd0, bus_err}, 1);
        check("tmo_illegal", {31'd0, illegal}, 0);
        check("tmo_rd_after_halt", rdh, 0);
        do_reset(1'b1);
        #1;
        check("tmo_refetch", {mem_rd, pc_inc, halted}, 3'b110);

        // Reset landing in EXECUTE must not produce a writeback
        instr = 16'h2650;
        do_reset(1'b1);
        repeat (2) @(negedge clk);
        #1;
        check("mid_exec", {reg_out_en, dst_sel}, 4'b1011);
        rst = 1'b1;
        #1;
        check("mid_rst_quiet", {reg_in_en, reg_out_en, mem_rd, pc_inc}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_fetch", {reg_in_en, mem_rd, pc_inc}, 3'b011);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
